// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller: 16 lines x 128-bit blocks.
// Hits complete in the request cycle; misses stall through an optional writeback and a block fill.
module dcache_ctrl (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [31:0]  p1_addr_i,
   input  logic [31:0]  p1_data_i,
   input  logic         p1_MemRead_i,
   input  logic         p1_MemWrite_i,
   output logic [31:0]  p1_data_o,
   output logic         p1_stall_o,
   output logic [31:0]  mem_addr_o,
   output logic [127:0] mem_data_o,
   output logic         mem_enable_o,
   output logic         mem_write_o,
   input  logic [127:0] mem_data_i,
   input  logic         mem_ack_i
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   state_t state, state_next;

   logic [15:0]  valid;
   logic [15:0]  dirty;
   logic [23:0]  tag_mem  [16];
   logic [127:0] data_mem [16];

   logic [23:0] req_tag;
   logic [3:0]  idx;
   logic [1:0]  word_sel;
   logic        req;
   logic        hit;
   logic        store_hit;
   logic        fill;
   logic        addr_unused;

   assign req_tag     = p1_addr_i[31:8];
   assign idx         = p1_addr_i[7:4];
   assign word_sel    = p1_addr_i[3:2];
   assign addr_unused = ^p1_addr_i[1:0];

   // A request with both strobes high behaves as a store.
   assign req       = p1_MemRead_i | p1_MemWrite_i;
   assign hit       = valid[idx] && (tag_mem[idx] == req_tag);
   assign store_hit = (state == IDLE) && p1_MemWrite_i && hit;
   assign fill      = (state == ALLOCATE) && mem_ack_i;

   always_comb begin
      state_next   = state;
      p1_stall_o   = 1'b0;
      p1_data_o    = '0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = {req_tag, idx, 4'b0000};
      mem_data_o   = data_mem[idx];
      case (state)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  if (!p1_MemWrite_i) begin
                     p1_data_o = data_mem[idx][{word_sel, 5'b00000} +: 32];
                  end
               end else begin
                  p1_stall_o = 1'b1;
                  state_next = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
               end
            end
         end
         WRITEBACK: begin
            p1_stall_o   = 1'b1;
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {tag_mem[idx], idx, 4'b0000};
            if (mem_ack_i) begin
               state_next = ALLOCATE;
            end
         end
         ALLOCATE: begin
            p1_stall_o   = 1'b1;
            mem_enable_o = 1'b1;
            if (mem_ack_i) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      // Reset must silence the pipeline and memory handshakes without waiting for a clock.
      if (rst_i) begin
         p1_stall_o   = 1'b0;
         p1_data_o    = '0;
         mem_enable_o = 1'b0;
         mem_write_o  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         valid <= '0;
         dirty <= '0;
      end else begin
         state <= state_next;
         if (fill) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
         end else if (store_hit) begin
            dirty[idx] <= 1'b1;
         end
      end
   end

   // Tags and data need no reset: valid bits gate every use of them.
   always_ff @(posedge clk_i) begin
      if (fill) begin
         tag_mem[idx]  <= req_tag;
         data_mem[idx] <= mem_data_i;
      end else if (store_hit) begin
         data_mem[idx][{word_sel, 5'b00000} +: 32] <= p1_data_i;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios, then random traffic against a
// line-level cache model and a sparse main-memory model that also acts as the memory responder.
module tb_dcache_ctrl;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [31:0]  p1_addr_i;
   logic [31:0]  p1_data_i;
   logic         p1_MemRead_i;
   logic         p1_MemWrite_i;
   logic [31:0]  p1_data_o;
   logic         p1_stall_o;
   logic [31:0]  mem_addr_o;
   logic [127:0] mem_data_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [127:0] mem_data_i;
   logic         mem_ack_i;

   int testsRun    = 0;
   int testsFailed = 0;

   logic         modelValid [16];
   logic         modelDirty [16];
   logic [23:0]  modelTag   [16];
   logic [127:0] modelData  [16];
   logic [127:0] memModel   [logic [31:0]];

   dcache_ctrl dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .p1_addr_i     (p1_addr_i),
      .p1_data_i     (p1_data_i),
      .p1_MemRead_i  (p1_MemRead_i),
      .p1_MemWrite_i (p1_MemWrite_i),
      .p1_data_o     (p1_data_o),
      .p1_stall_o    (p1_stall_o),
      .mem_addr_o    (mem_addr_o),
      .mem_data_o    (mem_data_o),
      .mem_enable_o  (mem_enable_o),
      .mem_write_o   (mem_write_o),
      .mem_data_i    (mem_data_i),
      .mem_ack_i     (mem_ack_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [127:0] memBlock(input logic [31:0] a);
      if (memModel.exists(a)) return memModel[a];
      return {a ^ 32'h1111_0000, ~a, a + 32'h0000_0077, a ^ 32'hCAFE_F00D};
   endfunction

   task automatic clearModel();
      for (int i = 0; i < 16; i++) begin
         modelValid[i] = 1'b0;
         modelDirty[i] = 1'b0;
      end
   endtask

   // One memory transaction: check the request, wait lat cycles, then pulse ack.
   task automatic memPhase(input logic expWrite, input logic [31:0] expAddr,
                           input logic [127:0] expData, input logic [127:0] fillData,
                           input int lat);
      @(negedge clk_i); #1;
      checkOutput("mem_enable", mem_enable_o, 1'b1);
      checkOutput("mem_write", mem_write_o, expWrite);
      checkOutput("mem_addr", mem_addr_o, expAddr);
      checkOutput("phase_stall", p1_stall_o, 1'b1);
      if (expWrite) checkOutput("wb_data", mem_data_o, expData);
      for (int i = 0; i < lat; i++) begin
         @(negedge clk_i); #1;
         checkOutput("wait_stall", p1_stall_o, 1'b1);
      end
      mem_data_i = fillData;
      mem_ack_i  = 1'b1;
      @(posedge clk_i); #1;
      mem_ack_i  = 1'b0;
      mem_data_i = {4{$urandom}};
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] data, input int lat);
      logic [3:0]   idx;
      logic [23:0]  tg;
      logic [1:0]   off;
      logic [31:0]  blk;
      logic [31:0]  victim;
      logic [127:0] fillBlk;
      idx = addr[7:4];
      tg  = addr[31:8];
      off = addr[3:2];
      blk = {tg, idx, 4'b0000};
      @(negedge clk_i);
      p1_addr_i     = addr;
      p1_data_i     = data;
      p1_MemRead_i  = rd;
      p1_MemWrite_i = wr;
      #1;
      if (!rd && !wr) begin
         checkOutput("idle_stall", p1_stall_o, 1'b0);
         checkOutput("idle_data", p1_data_o, 32'h0);
         @(posedge clk_i);
         return;
      end
      if (!(modelValid[idx] && modelTag[idx] == tg)) begin
         checkOutput("miss_stall", p1_stall_o, 1'b1);
         @(posedge clk_i);
         if (modelValid[idx] && modelDirty[idx]) begin
            victim = {modelTag[idx], idx, 4'b0000};
            memPhase(1'b1, victim, modelData[idx], 128'h0, lat);
            memModel[victim] = modelData[idx];
         end
         fillBlk = memBlock(blk);
         memPhase(1'b0, blk, 128'h0, fillBlk, lat);
         modelValid[idx] = 1'b1;
         modelDirty[idx] = 1'b0;
         modelTag[idx]   = tg;
         modelData[idx]  = fillBlk;
         @(negedge clk_i); #1;
      end
      checkOutput("hit_stall", p1_stall_o, 1'b0);
      checkOutput("hit_enable", mem_enable_o, 1'b0);
      checkOutput("hit_data", p1_data_o, wr ? 32'h0 : modelData[idx][off*32 +: 32]);
      if (wr) begin
         modelData[idx][off*32 +: 32] = data;
         modelDirty[idx] = 1'b1;
      end
      @(posedge clk_i);
   endtask

   // Abort a fill with reset, then show a stray ack is ignored and the line still misses.
   task automatic resetDuringAllocate(input logic [31:0] addr);
      @(negedge clk_i);
      p1_addr_i     = addr;
      p1_MemRead_i  = 1'b1;
      p1_MemWrite_i = 1'b0;
      #1;
      checkOutput("rst_miss_stall", p1_stall_o, 1'b1);
      @(posedge clk_i);
      @(negedge clk_i); #1;
      checkOutput("rst_alloc_enable", mem_enable_o, 1'b1);
      #1;
      rst_i = 1'b1;
      #1;
      checkOutput("rst_enable_drop", mem_enable_o, 1'b0);
      checkOutput("rst_write_drop", mem_write_o, 1'b0);
      checkOutput("rst_stall_drop", p1_stall_o, 1'b0);
      p1_MemRead_i = 1'b0;
      clearModel();
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      mem_data_i = {4{32'hBAD0_BAD0}};
      mem_ack_i  = 1'b1;
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      @(negedge clk_i); #1;
      checkOutput("stray_ack_enable", mem_enable_o, 1'b0);
      checkOutput("stray_ack_stall", p1_stall_o, 1'b0);
      applyStimulus(1'b1, 1'b0, addr, 32'h0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_i         = 1'b1;
      p1_addr_i     = '0;
      p1_data_i     = '0;
      p1_MemRead_i  = 1'b0;
      p1_MemWrite_i = 1'b0;
      mem_data_i    = '0;
      mem_ack_i     = 1'b0;
      clearModel();
      #1;
      checkOutput("reset_stall", p1_stall_o, 1'b0);
      checkOutput("reset_enable", mem_enable_o, 1'b0);
      checkOutput("reset_write", mem_write_o, 1'b0);
      checkOutput("reset_data", p1_data_o, 32'h0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;

      memModel[32'h0000_0100] = {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0};
      applyStimulus(1'b1, 1'b0, 32'h0000_0104, 32'h0, 2);
      applyStimulus(1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0104, 32'h0, 0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0204, 32'h0, 1);
      applyStimulus(1'b1, 1'b0, 32'h0000_0104, 32'h0, 1);
      applyStimulus(1'b1, 1'b1, 32'h0000_0108, 32'hA5A5_5A5A, 0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0108, 32'h0, 0);
      applyStimulus(1'b0, 1'b0, 32'h0000_0108, 32'h0, 0);
      resetDuringAllocate(32'h0000_0050);

      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         a = {22'h0, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                       $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 16 lines x 128-bit blocks, direct-mapped, write-back, write-allocate.
REQ-002 clk_i  in  1  single clock; all state updates on posedge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 p1_addr_i  in  32  MEM-stage byte address (ALU result).
REQ-005 p1_data_i  in  32  MEM-stage store data.
REQ-006 p1_MemRead_i  in  1  load request.
REQ-007 p1_MemWrite_i  in  1  store request.
REQ-008 p1_data_o  out  32  load data.
REQ-009 p1_stall_o  out  1  pipeline stall, high while the request cannot complete.
REQ-010 mem_addr_o  out  32  block address to main memory, low 4 bits zero.
REQ-011 mem_data_o  out  128  writeback block.
REQ-012 mem_enable_o  out  1  memory request valid.
REQ-013 mem_write_o  out  1  1 = block write, 0 = block read.
REQ-014 mem_data_i  in  128  fill block, valid when mem_ack_i = 1.
REQ-015 mem_ack_i  in  1  single-cycle completion pulse from memory.

Function
REQ-016 Address split SHALL be tag = addr[31:8] (24 b), index = addr[7:4], word offset = addr[3:2]; addr[1:0] ignored.
REQ-017 Per line, the block SHALL hold a valid bit, a dirty bit, a 24-bit tag and a 128-bit data block.
REQ-018 req = p1_MemRead_i | p1_MemWrite_i; with both high, the access SHALL be treated as a store.
REQ-019 hit = valid[index] & (tag[index] == addr tag), evaluated combinationally.
REQ-020 FSM states SHALL be IDLE, WRITEBACK and ALLOCATE.
REQ-021 IDLE, req & hit, load: p1_data_o SHALL return the addressed word in the same cycle; p1_stall_o = 0.
REQ-022 IDLE, req & hit, store: the addressed word SHALL be replaced at the next posedge and dirty set; p1_stall_o = 0.
REQ-023 IDLE, req & miss: p1_stall_o = 1 in that cycle; the FSM SHALL go to WRITEBACK if the victim is valid and dirty, else to ALLOCATE.
REQ-024 WRITEBACK: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 4'b0}, mem_data_o = victim block; on mem_ack_i the FSM SHALL go to ALLOCATE.
REQ-025 ALLOCATE: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {request tag, index, 4'b0}; on mem_ack_i the line SHALL be written with mem_data_i, valid = 1, dirty = 0, tag = request tag, and the FSM SHALL go to IDLE.
REQ-026 p1_stall_o SHALL be 1 throughout WRITEBACK and ALLOCATE; the held request then hits in IDLE on the cycle after the fill, giving a miss penalty of (memory latency + 1) cycles per transaction.
REQ-027 The request inputs SHALL be treated as stable while p1_stall_o = 1; the pipeline guarantees this.
REQ-028 mem_enable_o SHALL be 0 in IDLE, and mem_addr_o/mem_data_o are don't-care when mem_enable_o = 0.
REQ-029 mem_ack_i received in IDLE SHALL be ignored.
REQ-030 When req = 0, p1_stall_o SHALL be 0 and no array state changes.
REQ-031 p1_data_o SHALL be 0 when no load hit is in progress.

Reset
REQ-032 rst_i high SHALL immediately force state = IDLE, all valid and dirty bits = 0, mem_enable_o = 0, mem_write_o = 0 and p1_stall_o = 0, including mid-WRITEBACK or mid-ALLOCATE; data and tag arrays need not be cleared.
REQ-033 After rst_i is released, every first access to any line SHALL miss.

Verification
REQ-034 Cold load 0x0000_0104 after reset -> stall asserted; ALLOCATE with mem_addr_o = 0x0000_0100; mem returns block with word1 = 0xDEAD_BEEF; next cycle p1_data_o = 0xDEAD_BEEF and stall = 0.
REQ-035 Store 0x1234_5678 to 0x104 after the fill -> no stall; following load of 0x104 returns 0x1234_5678 and dirty[0] = 1.
REQ-036 Load 0x0000_0204 (same index 0, different tag) with line 0 dirty -> WRITEBACK to 0x100 with mem_data_o word1 = 0x1234_5678, then ALLOCATE at 0x200, then hit.
REQ-037 Clean conflict miss (line not dirty) -> straight to ALLOCATE; mem_write_o never asserted.
REQ-038 rst_i pulsed during ALLOCATE before mem_ack_i -> mem_enable_o drops at once; a later ack is ignored; a re-issued load misses again.
REQ-039 MemRead and MemWrite both high on a hit -> handled as a store; the word is updated and dirty set.
